// File: rtl/sys_array_pkg.sv
// Shared FSM encoding and job-timing helpers for the systolic array controller.
package sys_array_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_e;

  // Cycles spent streaming skewed lanes into the array.
  function automatic int unsigned feed_len(input int unsigned num_vec, input int unsigned array_l);
    return num_vec + array_l - 1;
  endfunction

  // FEED-relative cycle of the final capture (last vector, last column).
  function automatic int unsigned last_cap(input int unsigned num_vec, input int unsigned array_w,
                                           input int unsigned out_lat);
    return num_vec + array_w + out_lat - 2;
  endfunction

  // Clock edges from the accepting start edge to the edge that raises done.
  function automatic int unsigned job_len(input int unsigned num_vec, input int unsigned array_w,
                                          input int unsigned out_lat);
    return last_cap(num_vec, array_w, out_lat) + 2;
  endfunction

  // Counter width with headroom for the whole FEED+DRAIN span.
  function automatic int unsigned cnt_w(input int unsigned out_lat, input int unsigned num_vec,
                                        input int unsigned array_w, input int unsigned array_l);
    return $clog2(out_lat + num_vec + array_w + array_l + 1);
  endfunction

  // Width of the skew-mux cycle index.
  function automatic int unsigned skew_w(input int unsigned num_vec, input int unsigned array_l);
    return $clog2(num_vec + array_l + 1);
  endfunction

  localparam int unsigned FEED_LEN = feed_len(4, 4);
  localparam int unsigned JOB_LEN  = job_len(4, 4, 4);

endpackage

// File: rtl/sys_array_skew.sv
// Lane skew / zero-fill mux: lane i carries X[t-i][i] while in range, else 0.
module sys_array_skew
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_L    = 4,
  parameter int unsigned NUM_VEC    = 4
) (
  input  logic [skew_w(NUM_VEC, ARRAY_L)-1:0]   t_i,
  input  logic                                  valid_i,
  input  logic [DATA_WIDTH*ARRAY_L*NUM_VEC-1:0] vectors_i,
  output logic [DATA_WIDTH*ARRAY_L-1:0]         lanes_o
);

  // Select the diagonal element for every lane at cycle t_i.
  always_comb begin
    int unsigned t;
    int unsigned k;
    lanes_o = '0;
    t       = 32'(t_i);
    k       = 0;
    if (valid_i) begin
      for (int unsigned i = 0; i < ARRAY_L; i++) begin
        k = t - i;
        if (t >= i && k < NUM_VEC) begin
          lanes_o[i*DATA_WIDTH +: DATA_WIDTH] = vectors_i[(k*ARRAY_L+i)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

endmodule

// File: rtl/sys_array_ctrl.sv
// Job controller for a weight-stationary systolic array: loads weights,
// streams skewed input vectors, and captures the diagonal column outputs.
module sys_array_ctrl
  import sys_array_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ARRAY_W    = 4,
  parameter int unsigned ARRAY_L    = 4,
  parameter int unsigned NUM_VEC    = 4,
  parameter int unsigned OUT_LAT    = ARRAY_L
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      start,
  output logic                                      ready,
  input  logic [DATA_WIDTH*ARRAY_W*ARRAY_L-1:0]     weights_in,
  input  logic [DATA_WIDTH*ARRAY_L*NUM_VEC-1:0]     vectors_in,
  output logic                                      param_load,
  output logic [DATA_WIDTH*ARRAY_W*ARRAY_L-1:0]     parameter_data,
  output logic [DATA_WIDTH*ARRAY_L-1:0]             input_module,
  input  logic [2*DATA_WIDTH*ARRAY_W-1:0]           out_module,
  output logic [2*DATA_WIDTH*ARRAY_W*NUM_VEC-1:0]   results,
  output logic                                      done
);

  localparam int unsigned FEED_N = feed_len(NUM_VEC, ARRAY_L);
  localparam int unsigned LAST_T = last_cap(NUM_VEC, ARRAY_W, OUT_LAT);
  localparam int unsigned CW     = cnt_w(OUT_LAT, NUM_VEC, ARRAY_W, ARRAY_L);
  localparam int unsigned TW     = skew_w(NUM_VEC, ARRAY_L);
  localparam int unsigned RW     = 2 * DATA_WIDTH;

  state_e                                    state_q;
  logic                                      ready_q;
  logic                                      param_load_q;
  logic                                      done_q;
  logic [DATA_WIDTH*ARRAY_W*ARRAY_L-1:0]     pdata_q;
  logic [DATA_WIDTH*ARRAY_L*NUM_VEC-1:0]     vec_q;
  logic [DATA_WIDTH*ARRAY_L-1:0]             in_q;
  logic [RW*ARRAY_W*NUM_VEC-1:0]             res_q;
  logic [CW-1:0]                             cnt_q;

  logic [TW-1:0]                             skew_t;
  logic                                      skew_v;
  logic [DATA_WIDTH*ARRAY_L-1:0]             skew_lanes;

  // Lane data is registered, so the mux looks one FEED cycle ahead.
  always_comb begin
    skew_v = 1'b0;
    skew_t = '0;
    if (state_q == S_LOAD) begin
      skew_v = 1'b1;
    end else if (state_q == S_FEED && cnt_q != CW'(FEED_N - 1)) begin
      skew_v = 1'b1;
      skew_t = TW'(cnt_q + 1'b1);
    end
  end

  sys_array_skew #(
    .DATA_WIDTH (DATA_WIDTH),
    .ARRAY_L    (ARRAY_L),
    .NUM_VEC    (NUM_VEC)
  ) u_skew (
    .t_i       (skew_t),
    .valid_i   (skew_v),
    .vectors_i (vec_q),
    .lanes_o   (skew_lanes)
  );

  // Job FSM with registered outputs and diagonal result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b1;
      param_load_q <= 1'b0;
      done_q       <= 1'b0;
      pdata_q      <= '0;
      vec_q        <= '0;
      in_q         <= '0;
      res_q        <= '0;
      cnt_q        <= '0;
    end else begin
      done_q <= 1'b0;
      if (state_q == S_FEED || state_q == S_DRAIN) begin
        for (int unsigned k = 0; k < NUM_VEC; k++) begin
          for (int unsigned j = 0; j < ARRAY_W; j++) begin
            if (cnt_q == CW'(k + j + OUT_LAT)) begin
              res_q[(k*ARRAY_W+j)*RW +: RW] <= out_module[j*RW +: RW];
            end
          end
        end
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pdata_q      <= weights_in;
            vec_q        <= vectors_in;
            param_load_q <= 1'b1;
            ready_q      <= 1'b0;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          param_load_q <= 1'b0;
          cnt_q        <= '0;
          in_q         <= skew_lanes;
          state_q      <= S_FEED;
        end
        S_FEED: begin
          cnt_q <= cnt_q + 1'b1;
          in_q  <= skew_lanes;
          if (cnt_q == CW'(FEED_N - 1)) begin
            state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          cnt_q <= cnt_q + 1'b1;
          in_q  <= '0;
          if (cnt_q == CW'(LAST_T)) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          cnt_q   <= '0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign ready          = ready_q;
  assign param_load     = param_load_q;
  assign parameter_data = pdata_q;
  assign input_module   = in_q;
  assign results        = res_q;
  assign done           = done_q;

endmodule

// File: tb/tb_sys_array_ctrl.sv
// Directed bench for sys_array_ctrl driving a behavioural 4x4 weight-stationary array.
module tb_sys_array_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned W  = 4;
  localparam int unsigned L  = 4;
  localparam int unsigned N  = 4;
  // Edges from start to done: LOAD + captures up to t = (N-1)+(W-1)+OUT_LAT, then DONE.
  localparam int LAT_EXP = 12;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    start;
  logic                    ready;
  logic [DW*W*L-1:0]       weights_in;
  logic [DW*L*N-1:0]       vectors_in;
  logic                    param_load;
  logic [DW*W*L-1:0]       parameter_data;
  logic [DW*L-1:0]         input_module;
  logic [2*DW*W-1:0]       out_module;
  logic [2*DW*W*N-1:0]     results;
  logic                    done;

  int n_chk = 0;
  int n_err = 0;

  sys_array_ctrl #(
    .DATA_WIDTH (DW),
    .ARRAY_W    (W),
    .ARRAY_L    (L),
    .NUM_VEC    (N),
    .OUT_LAT    (L)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .ready          (ready),
    .weights_in     (weights_in),
    .vectors_in     (vectors_in),
    .param_load     (param_load),
    .parameter_data (parameter_data),
    .input_module   (input_module),
    .out_module     (out_module),
    .results        (results),
    .done           (done)
  );

  always #5 clk = ~clk;

  // Behavioural systolic array: activations move right, partial sums move down.
  logic [7:0]  a_q  [L][W];
  logic [15:0] p_q  [L][W];
  logic [7:0]  wm_q [L][W];

  always @(posedge clk) begin : array_model
    logic [7:0]  ain;
    logic [15:0] pin;
    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < W; j++) begin
        if (reset) begin
          a_q[i][j]  <= '0;
          p_q[i][j]  <= '0;
          wm_q[i][j] <= '0;
        end else begin
          if (param_load) wm_q[i][j] <= parameter_data[(i*W+j)*DW +: DW];
          if (j == 0) ain = input_module[i*DW +: DW];
          else        ain = a_q[i][j-1];
          if (i == 0) pin = 16'd0;
          else        pin = p_q[i-1][j];
          a_q[i][j] <= ain;
          p_q[i][j] <= pin + 16'(ain) * 16'(wm_q[i][j]);
        end
      end
    end
  end

  always_comb begin
    out_module = '0;
    for (int j = 0; j < W; j++) out_module[j*16 +: 16] = p_q[L-1][j];
  end

  // Hand-derived lane contents for X[k][i] = 4k+i+1 over FEED cycles 0..6.
  byte unsigned sk_exp [L][7] = '{'{1, 5, 9, 13, 0, 0, 0},
                                  '{0, 2, 6, 10, 14, 0, 0},
                                  '{0, 0, 3, 7, 11, 15, 0},
                                  '{0, 0, 0, 4, 8, 12, 16}};

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic run_job(input logic [DW*W*L-1:0] w, input logic [DW*L*N-1:0] v,
                         input bit skew_chk, input logic [2*DW*W*N-1:0] exp_res, input string name);
    int lat;
    weights_in = w;
    vectors_in = v;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_val({name, " load strobe"}, 256'(param_load), 256'(1));
    check_val({name, " load data"}, 256'(parameter_data), 256'(w));
    check_val({name, " ready busy"}, 256'(ready), 256'(0));
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (skew_chk && lat >= 1 && lat <= 7) begin
        for (int i = 0; i < L; i++) begin
          check_val($sformatf("%s skew l%0d t%0d", name, i, lat-1),
                    256'(input_module[i*DW +: DW]), 256'(sk_exp[i][lat-1]));
        end
      end
    end
    check_val({name, " latency"}, 256'(lat), 256'(LAT_EXP));
    check_val({name, " results"}, 256'(results), 256'(exp_res));
    @(posedge clk); #1;
    check_val({name, " done pulse width"}, 256'(done), 256'(0));
    check_val({name, " ready after"}, 256'(ready), 256'(1));
  endtask

  logic [DW*W*L-1:0]   w_a, w_b, w_c;
  logic [DW*L*N-1:0]   x_id, x_b, x_c;
  logic [2*DW*W*N-1:0] y_a, y_b, y_c;

  initial begin
    int pl_cnt;
    int done_at;
    int ready_at;
    int pl_at;
    int wait_cnt;

    for (int i = 0; i < L; i++) begin
      for (int j = 0; j < W; j++) begin
        w_a[(i*W+j)*DW +: DW] = 8'(i*W + j + 1);
        w_b[(i*W+j)*DW +: DW] = (i == j) ? 8'd2 : 8'd0;
      end
    end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < L; i++) begin
        x_id[(k*L+i)*DW +: DW] = (k == i) ? 8'd1 : 8'd0;
        x_b[(k*L+i)*DW +: DW]  = 8'(4*k + i + 1);
      end
      for (int j = 0; j < W; j++) begin
        y_a[(k*W+j)*16 +: 16] = 16'(4*k + j + 1);
        y_b[(k*W+j)*16 +: 16] = 16'(2*(4*k + j + 1));
        y_c[(k*W+j)*16 +: 16] = 16'd63492;
      end
    end
    w_c = '1;
    x_c = '1;

    reset      = 1'b1;
    start      = 1'b0;
    weights_in = '0;
    vectors_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst ready", 256'(ready), 256'(1));
    check_val("rst param_load", 256'(param_load), 256'(0));
    check_val("rst done", 256'(done), 256'(0));
    check_val("rst input_module", 256'(input_module), 256'(0));
    check_val("rst parameter_data", 256'(parameter_data), 256'(0));
    check_val("rst results", 256'(results), 256'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    run_job(w_a, x_id, 1'b0, y_a, "ident");
    repeat (3) @(posedge clk);
    #1;
    check_val("ident hold", 256'(results), 256'(y_a));

    run_job(w_b, x_b, 1'b1, y_b, "skew");
    run_job(w_c, x_c, 1'b0, y_c, "wrap");

    // start held high across a whole job
    weights_in = w_a;
    vectors_in = x_id;
    start      = 1'b1;
    @(posedge clk); #1;
    pl_cnt = 0; done_at = -1; ready_at = -1; pl_at = -1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      if (param_load) begin pl_cnt++; pl_at = c; end
      if (done && done_at < 0) done_at = c;
      if (ready && ready_at < 0) ready_at = c;
    end
    start = 1'b0;
    check_val("hold done cycle", 256'(done_at), 256'(LAT_EXP));
    check_val("hold ready cycle", 256'(ready_at), 256'(LAT_EXP + 1));
    check_val("hold second load cycle", 256'(pl_at), 256'(LAT_EXP + 2));
    check_val("hold load count", 256'(pl_cnt), 256'(1));
    wait_cnt = 0;
    while (done !== 1'b1 && wait_cnt < 40) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check_val("hold second done", 256'(done), 256'(1));
    check_val("hold second results", 256'(results), 256'(y_a));
    @(posedge clk); #1;

    // reset during FEED aborts the job
    weights_in = w_b;
    vectors_in = x_b;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check_val("abort ready", 256'(ready), 256'(1));
    check_val("abort param_load", 256'(param_load), 256'(0));
    check_val("abort done", 256'(done), 256'(0));
    check_val("abort input_module", 256'(input_module), 256'(0));
    check_val("abort parameter_data", 256'(parameter_data), 256'(0));
    check_val("abort results", 256'(results), 256'(0));
    reset = 1'b0;
    run_job(w_c, x_c, 1'b0, y_c, "post-abort");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
